// File: rtl/ram_pkg.sv
// Shared definitions for the clear-on-reset dual-port RAM: FSM encoding and
// read-during-write mode selectors.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RDW_READ_OLD    = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/lane_merge.sv
// Lane-masked word merge: lanes with mask set take new_word, the rest keep
// old_word.
module lane_merge #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] new_word,
  input  logic [LANES-1:0] mask,
  output logic [WIDTH-1:0] merged
);

  localparam int LW = WIDTH / LANES;

  always_comb begin
    merged = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) merged[i*LW +: LW] = new_word[i*LW +: LW];
    end
  end

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with lane write mask, self-clearing after reset and
// selectable read-during-write behaviour; optional output register stage.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int DEPTH    = 10,
  parameter int WIDTH    = 8,
  parameter int LANES    = 1,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [LANES-1:0] wr_mask,
  input  logic             rd_en,
  input  logic [DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             ready
);

  localparam int WORDS = 2**DEPTH;

  logic [WIDTH-1:0] mem [WORDS];

  state_e           state_q, state_d;
  logic [DEPTH-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  assign ready = (state_q == ST_READY);

  logic             user_we, rd_fire_p0, mem_we;
  logic [WIDTH-1:0] wr_old, wr_merged, mem_wdata, rd_word_p0;
  logic [DEPTH-1:0] mem_waddr;

  assign user_we    = ready && wr_en;
  assign rd_fire_p0 = ready && rd_en;
  assign wr_old     = mem[wr_addr];

  // Same merged word feeds the array write and the write-first bypass.
  lane_merge #(.WIDTH(WIDTH), .LANES(LANES)) u_merge (
    .old_word (wr_old),
    .new_word (wr_data),
    .mask     (wr_mask),
    .merged   (wr_merged)
  );

  assign mem_we    = !rst && (clr_we || (user_we && (|wr_mask)));
  assign mem_waddr = clr_we ? clr_cnt_q : wr_addr;
  assign mem_wdata = clr_we ? '0 : wr_merged;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  generate
    if (RDW_MODE == RDW_WRITE_FIRST) begin : g_wr_first
      assign rd_word_p0 = (user_we && (wr_addr == rd_addr)) ? wr_merged : mem[rd_addr];
    end else begin : g_rd_old
      assign rd_word_p0 = mem[rd_addr];
    end
  endgenerate

  // ---- stage p0 -> p1: array read ----
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= rd_fire_p0;
      if (rd_fire_p0) data_p1 <= rd_word_p0;
    end
  end

  // ---- stage p1 -> p2: optional output register ----
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic             vld_p2;
      logic [WIDTH-1:0] data_p2;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p2  <= 1'b0;
          data_p2 <= '0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) data_p2 <= data_p1;
        end
      end

      assign rd_valid = vld_p2;
      assign rd_data  = data_p2;
    end else begin : g_no_out_reg
      assign rd_valid = vld_p1;
      assign rd_data  = data_p1;
    end
  endgenerate

endmodule

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 SHALL have parameter DEPTH, default 10: address width in bits; the array holds 2**DEPTH words.
REQ-002 SHALL have parameter WIDTH, default 8: word width in bits.
REQ-003 SHALL have parameter LANES, default 1: number of write-mask lanes; WIDTH%LANES==0; lane width LW=WIDTH/LANES.
REQ-004 SHALL have parameter RDW_MODE, default 0: 0=read-old, 1=write-first on same-address same-cycle read/write.
REQ-005 SHALL have parameter OUT_REG, default 0: 1 adds one output register stage.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on posedge clk.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port wr_en, input, 1: write request.
REQ-009 SHALL have port wr_addr, input, DEPTH: write address.
REQ-010 SHALL have port wr_data, input, WIDTH: write data.
REQ-011 SHALL have port wr_mask, input, LANES: lane i writes bits [i*LW +: LW] when set.
REQ-012 SHALL have port rd_en, input, 1: read request.
REQ-013 SHALL have port rd_addr, input, DEPTH: read address.
REQ-014 SHALL have port rd_data, output, WIDTH: read data, valid only while rd_valid=1.
REQ-015 SHALL have port rd_valid, output, 1: rd_data carries the result of an accepted read.
REQ-016 SHALL have port ready, output, 1: clear complete; requests are accepted.

Function
REQ-017 SHALL implement a two-state FSM: CLEAR and READY.
REQ-018 In CLEAR, the block SHALL write all-zero to address clr_cnt each cycle and increment clr_cnt (DEPTH bits).
REQ-019 In CLEAR, the FSM SHALL move to READY in the cycle after clr_cnt=2**DEPTH-1 is written; the clear lasts exactly 2**DEPTH cycles.
REQ-020 ready SHALL be 1 iff the state is READY (registered).
REQ-021 In CLEAR, wr_en and rd_en SHALL be ignored: no user write, no rd_valid.
REQ-022 In READY with wr_en=1, the block SHALL write only the masked lanes; unmasked lanes SHALL retain their value; wr_mask=0 is a no-op.
REQ-023 Read and write ports SHALL be independent and both SHALL be accepted in the same cycle.
REQ-024 Read latency from rd_en to rd_valid SHALL be 1+OUT_REG cycles, fully pipelined at one read per cycle.
REQ-025 On a same-cycle read/write of the same address with RDW_MODE=0, the read SHALL return the pre-write word.
REQ-026 On a same-cycle read/write of the same address with RDW_MODE=1, the read SHALL return the merged word: masked lanes from wr_data, others from the old word.
REQ-027 Reads with no rd_en SHALL leave rd_data held and rd_valid=0.
REQ-028 Addresses SHALL be fully decoded; there is no out-of-range case and no wrap logic beyond DEPTH bits.

Reset
REQ-029 rst=1 at a clock edge SHALL put the FSM in CLEAR, set clr_cnt=0, ready=0, rd_valid=0 (all stages) and rd_data=0.
REQ-030 rst asserted mid-clear or mid-read SHALL restart the clear from address 0 and drop in-flight reads.
REQ-031 While rst=1, no array write (user or clear) SHALL occur; the clear begins in the first cycle with rst=0.
REQ-032 The array SHALL have no initial-block contents; zeroing is done solely by the clear FSM.

Structure
REQ-033 FSM state encoding (CLEAR, READY) and RDW_MODE constants SHALL live in a shared package ram_pkg.
REQ-034 Lane-masked merge logic SHALL be one sub-module lane_merge (old, new, mask -> merged), reused for the write path and the write-first bypass.
REQ-035 The array SHALL be a single reg array inferable as simple dual-port RAM; the output stage SHALL be generated on OUT_REG.

Verification (DEPTH=4, WIDTH=16, LANES=2 unless stated)
REQ-036 rst 1 cycle, then idle -> ready=0 for 16 cycles, ready=1 on cycle 17; read of every address returns 0x0000.
REQ-037 Write 0xABCD to addr 3 with mask=2'b01 over 0x1234 -> read returns 0x12CD one cycle later (two with OUT_REG=1).
REQ-038 Same cycle wr addr 5 = 0xBEEF mask 2'b11, rd addr 5, old value 0x0000 -> RDW_MODE=0 returns 0x0000, RDW_MODE=1 returns 0xBEEF.
REQ-039 Back-to-back reads of addrs 0..15 with rd_en held -> rd_valid high for 16 consecutive cycles, data in address order.
REQ-040 rst pulsed at clear cycle 7, plus wr_en during CLEAR -> clear restarts, ready rises 16 cycles after rst falls, all words read back 0.
REQ-041 rst asserted with a read in flight (OUT_REG=1) -> rd_valid never rises for that read and rd_data=0.
